// File: rtl/bcd_frame_collector.sv
// Collects a valid/ready stream of BCD digits into a packed NUM_DIGITS-digit frame
// and holds the completed frame until the downstream consumer takes it.
module bcd_frame_collector #(
    parameter int unsigned NUM_DIGITS = 300,
    parameter bit          MSD_FIRST  = 1'b1,
    parameter int unsigned CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              bcd_digit,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] dec,
    output logic [CNT_W-1:0]        out_count,
    output logic                    err_digit
);

    localparam int unsigned DEC_W = 4 * NUM_DIGITS;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [DEC_W-1:0]   dec_q, dec_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               err_q, err_d;

    logic               accept;
    logic               frame_done;
    logic               digit_bad;
    logic [3:0]         digit_stored;
    logic [CNT_W-1:0]   count_inc;

    // Accept qualification and per-digit sanitising
    always_comb begin
        accept       = in_valid && (state_q == COLLECT);
        digit_bad    = (bcd_digit > 4'd9);
        digit_stored = digit_bad ? 4'd0 : bcd_digit;
        count_inc    = count_q + CNT_W'(1);
        frame_done   = in_last || (count_q == CNT_W'(NUM_DIGITS - 1));
    end

    // Next-state and datapath update; clear overrides accept and consume
    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        count_d     = count_q;
        out_count_d = out_count_q;
        err_d       = err_q;

        if (clear) begin
            state_d     = COLLECT;
            dec_d       = '0;
            count_d     = '0;
            out_count_d = '0;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        if (MSD_FIRST) begin
                            dec_d = DEC_W'({dec_q, digit_stored});
                        end else begin
                            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                                if (count_q == CNT_W'(i)) begin
                                    dec_d[4*i +: 4] = digit_stored;
                                end
                            end
                        end
                        if (digit_bad) begin
                            err_d = 1'b1;
                        end
                        count_d = count_inc;
                        if (frame_done) begin
                            state_d     = HOLD;
                            out_count_d = count_inc;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d     = COLLECT;
                        dec_d       = '0;
                        count_d     = '0;
                        out_count_d = '0;
                        err_d       = 1'b0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= COLLECT;
            dec_q       <= '0;
            count_q     <= '0;
            out_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            count_q     <= count_d;
            out_count_q <= out_count_d;
            err_q       <= err_d;
        end
    end

    // Handshake flags are pure decodes of the registered state
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign dec       = dec_q;
    assign out_count = out_count_q;
    assign err_digit = err_q;

endmodule

// File: tb/tb_bcd_frame_collector.sv
// Scoreboard bench: two 4-digit collectors (MSD/LSD first) on shared stimulus
// plus a 300-digit MSD-first collector, all checked against a digit-list model.
module tb_bcd_frame_collector;

    localparam int unsigned W4 = $clog2(4 + 1);
    localparam int unsigned WB = $clog2(300 + 1);

    typedef struct {
        logic [1199:0] dec;
        int            cnt;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, clear, in_valid, in_last, out_ready;
    logic [3:0]    bcd_digit;
    logic          m_in_ready, m_out_valid, m_err;
    logic [15:0]   m_dec;
    logic [W4-1:0] m_out_count;
    logic          l_in_ready, l_out_valid, l_err;
    logic [15:0]   l_dec;
    logic [W4-1:0] l_out_count;

    logic          b_clear, b_in_valid, b_in_last, b_out_ready;
    logic [3:0]    b_digit;
    logic          b_in_ready, b_out_valid, b_err;
    logic [1199:0] b_dec;
    logic [WB-1:0] b_out_count;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_m[$];
    exp_t exp_l[$];
    exp_t exp_b[$];
    logic [3:0] cur4[$];
    logic [3:0] cur_b[$];

    bcd_frame_collector #(.NUM_DIGITS(4), .MSD_FIRST(1'b1)) u_m (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(m_in_ready), .bcd_digit(bcd_digit), .in_last(in_last),
        .out_valid(m_out_valid), .out_ready(out_ready), .dec(m_dec),
        .out_count(m_out_count), .err_digit(m_err));

    bcd_frame_collector #(.NUM_DIGITS(4), .MSD_FIRST(1'b0)) u_l (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid),
        .in_ready(l_in_ready), .bcd_digit(bcd_digit), .in_last(in_last),
        .out_valid(l_out_valid), .out_ready(out_ready), .dec(l_dec),
        .out_count(l_out_count), .err_digit(l_err));

    bcd_frame_collector u_b (
        .clk(clk), .reset_n(reset_n), .clear(b_clear), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .bcd_digit(b_digit), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .dec(b_dec),
        .out_count(b_out_count), .err_digit(b_err));

    // Reference: digit k of an n-digit frame lands at nibble n-1-k (MSD first) or k
    function automatic exp_t build(input logic [3:0] dig[$], input bit msd);
        exp_t e;
        int   n;
        e.dec = '0;
        e.err = 1'b0;
        n     = dig.size();
        e.cnt = n;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = msd ? (n - 1 - k) : k;
            if (dig[k] > 4'd9) e.err = 1'b1;
            else               e.dec[idx*4 +: 4] = dig[k];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [1199:0] act, input logic [1199:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send4(input logic [3:0] d, input logic last, input bit rnd);
        int n = 0;
        bit ok;
        in_valid  = 1'b1;
        bcd_digit = d;
        in_last   = last;
        @(negedge clk);
        while (!m_in_ready && n < 200) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
            @(negedge clk);
        end
        ok = m_in_ready;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send4_timeout in_ready actual=0 required=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        if (ok) begin
            cur4.push_back(d);
            if (last || cur4.size() == 4) begin
                exp_m.push_back(build(cur4, 1'b1));
                exp_l.push_back(build(cur4, 1'b0));
                cur4.delete();
            end
        end
    endtask

    task automatic idle4(input int n, input bit rnd);
        in_valid = 1'b0;
        repeat (n) begin
            in_last   = 1'($urandom_range(0, 1));
            bcd_digit = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        in_last = 1'b0;
    endtask

    task automatic clear4();
        clear     = 1'b1;
        in_valid  = 1'b1;
        bcd_digit = 4'd8;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        cur4.delete();
        exp_m.delete();
        exp_l.delete();
    endtask

    task automatic send_b(input logic [3:0] d);
        int n = 0;
        bit ok;
        b_in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
        b_in_valid = 1'b1;
        b_digit    = d;
        @(negedge clk);
        while (!b_in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
            @(negedge clk);
        end
        ok = b_in_ready;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_b_timeout in_ready actual=0 required=1");
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        if (ok) begin
            cur_b.push_back(d);
            if (cur_b.size() == 300) begin
                exp_b.push_back(build(cur_b, 1'b1));
                cur_b.delete();
            end
        end
    endtask

    // Monitor: whenever a frame is taken, pop the oldest expectation and compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (m_out_valid && out_ready) begin
                    if (exp_m.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL m_frame unexpected actual=%0h required=none", m_dec);
                    end else begin
                        e = exp_m.pop_front();
                        chk("m_dec", 1200'(m_dec), e.dec);
                        chk("m_count", 1200'(m_out_count), 1200'(e.cnt));
                        chk("m_err", 1200'(m_err), 1200'(e.err));
                    end
                end
                if (l_out_valid && out_ready) begin
                    if (exp_l.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL l_frame unexpected actual=%0h required=none", l_dec);
                    end else begin
                        e = exp_l.pop_front();
                        chk("l_dec", 1200'(l_dec), e.dec);
                        chk("l_count", 1200'(l_out_count), 1200'(e.cnt));
                        chk("l_err", 1200'(l_err), 1200'(e.err));
                    end
                end
                if (b_out_valid && b_out_ready) begin
                    if (exp_b.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL b_frame unexpected actual=%0h required=none", b_out_count);
                    end else begin
                        e = exp_b.pop_front();
                        chk("b_dec", b_dec, e.dec);
                        chk("b_count", 1200'(b_out_count), 1200'(e.cnt));
                        chk("b_err", 1200'(b_err), 1200'(e.err));
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        bcd_digit = 4'd0; out_ready = 1'b0;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0; b_digit = 4'd0;
        b_out_ready = 1'b1;
        #12;
        chk("rst_dec", 1200'(m_dec), '0);
        chk("rst_count", 1200'(m_out_count), '0);
        chk("rst_err", 1200'(m_err), '0);
        chk("rst_out_valid", 1200'(m_out_valid), '0);
        chk("rst_in_ready", 1200'(m_in_ready), 1200'(1));
        chk("rst_b_dec", b_dec, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Full frame held with out_ready low, extra in_valid ignored
        send4(4'd1, 1'b0, 1'b0);
        send4(4'd2, 1'b0, 1'b0);
        send4(4'd3, 1'b0, 1'b0);
        chk("t1_valid_early", 1200'(m_out_valid), '0);
        send4(4'd4, 1'b0, 1'b0);
        chk("t1_valid", 1200'(m_out_valid), 1200'(1));
        chk("t1_in_ready", 1200'(m_in_ready), '0);
        chk("t1_dec", 1200'(m_dec), 1200'(16'h1234));
        chk("t1_dec_lsd", 1200'(l_dec), 1200'(16'h4321));
        chk("t1_count", 1200'(m_out_count), 1200'(4));
        in_valid = 1'b1; bcd_digit = 4'd9;
        repeat (5) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        chk("t1_hold_dec", 1200'(m_dec), 1200'(16'h1234));
        chk("t1_hold_valid", 1200'(m_out_valid), 1200'(1));
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t1_consumed_valid", 1200'(m_out_valid), '0);
        chk("t1_consumed_dec", 1200'(m_dec), '0);
        chk("t1_consumed_count", 1200'(m_out_count), '0);
        chk("t1_in_ready_back", 1200'(m_in_ready), 1200'(1));

        // Early termination
        send4(4'd7, 1'b0, 1'b0);
        send4(4'd5, 1'b1, 1'b0);
        chk("t2_dec", 1200'(m_dec), 1200'(16'h0075));
        chk("t2_dec_lsd", 1200'(l_dec), 1200'(16'h0057));
        chk("t2_count", 1200'(m_out_count), 1200'(2));
        chk("t2_err", 1200'(m_err), '0);
        idle4(2, 1'b0);
        send4(4'd1, 1'b0, 1'b0);
        send4(4'd2, 1'b0, 1'b0);
        send4(4'd3, 1'b1, 1'b0);
        chk("t3_dec_lsd", 1200'(l_dec), 1200'(16'h0321));
        chk("t3_count_lsd", 1200'(l_out_count), 1200'(3));
        idle4(2, 1'b0);

        // Invalid digits
        send4(4'h9, 1'b0, 1'b0);
        send4(4'hA, 1'b0, 1'b0);
        send4(4'h3, 1'b0, 1'b0);
        send4(4'hF, 1'b0, 1'b0);
        chk("t4_dec", 1200'(m_dec), 1200'(16'h9030));
        chk("t4_err", 1200'(m_err), 1200'(1));
        idle4(2, 1'b0);
        send4(4'd2, 1'b1, 1'b0);
        chk("t4_err_cleared", 1200'(m_err), '0);
        chk("t4_dec2", 1200'(m_dec), 1200'(16'h0002));
        idle4(2, 1'b0);

        // Clear mid-frame drops the partial frame and the concurrent digit
        send4(4'd4, 1'b0, 1'b0);
        send4(4'd6, 1'b0, 1'b0);
        clear4();
        chk("t5_clear_dec", 1200'(m_dec), '0);
        chk("t5_clear_dec_lsd", 1200'(l_dec), '0);
        chk("t5_clear_in_ready", 1200'(m_in_ready), 1200'(1));
        send4(4'd5, 1'b1, 1'b0);
        chk("t5_after_dec", 1200'(m_dec), 1200'(16'h0005));
        chk("t5_after_count", 1200'(m_out_count), 1200'(1));
        idle4(2, 1'b0);
        out_ready = 1'b0;
        send4(4'd1, 1'b0, 1'b0);
        send4(4'd2, 1'b1, 1'b0);
        chk("t5_hold_valid", 1200'(m_out_valid), 1200'(1));
        clear4();
        chk("t5_hold_clear_valid", 1200'(m_out_valid), '0);
        chk("t5_hold_clear_dec", 1200'(m_dec), '0);
        out_ready = 1'b1;
        idle4(2, 1'b0);

        // Randomised digits, frame ends, gaps and consumer back-pressure
        for (int i = 0; i < 150; i++) begin
            send4(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b1);
            if ($urandom_range(0, 3) == 0) idle4(1, 1'b1);
        end
        out_ready = 1'b1;
        send4(4'd0, 1'b1, 1'b0);
        idle4(4, 1'b0);
        chk("rand_m_drained", 1200'(exp_m.size()), '0);
        chk("rand_l_drained", 1200'(exp_l.size()), '0);

        // 300-digit frame with an asynchronous reset mid-stream, then a full run
        for (int i = 0; i < 150; i++) send_b(4'(i % 10));
        #1 reset_n = 1'b0;
        #1;
        chk("b_async_rst_dec", b_dec, '0);
        chk("b_async_rst_valid", 1200'(b_out_valid), '0);
        chk("b_async_rst_ready", 1200'(b_in_ready), 1200'(1));
        #1 reset_n = 1'b1;
        cur_b.delete();
        for (int i = 0; i < 300; i++) send_b(4'(i % 10));
        chk("b_full_valid", 1200'(b_out_valid), 1200'(1));
        chk("b_full_count", 1200'(b_out_count), 1200'(300));
        chk("b_full_in_ready", 1200'(b_in_ready), '0);
        repeat (3) begin @(posedge clk); #1; end
        chk("b_drained", 1200'(exp_b.size()), '0);
        chk("b_released", 1200'(b_out_valid), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_frame_collector.md
Name: bcd_frame_collector

Overview:
- Parametrised successor to the fixed 300-digit BCD shift collector.
- Accepts a stream of 4-bit BCD digits over a valid/ready handshake and assembles them into a packed NUM_DIGITS-digit frame.
- Supports early frame termination, MSD-first or LSD-first arrival, and invalid-digit flagging.
- Holds each completed frame until a downstream consumer takes it; sits between the digit-entry front end and the decimal datapath.

Parameters:
- NUM_DIGITS, 300: digits per frame; dec width is 4*NUM_DIGITS.
- MSD_FIRST, 1: 1 = first digit received is most significant (shift-in at LSB nibble); 0 = first digit received is least significant (written at nibble index digit_count).
- CNT_W, $clog2(NUM_DIGITS+1): width of the digit counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous frame abort; discards the partial or held frame
- in_valid  input  1  bcd_digit is valid this cycle
- in_ready  output  1  collector can accept a digit
- bcd_digit  input  4  BCD digit
- in_last  input  1  accepted digit is the final digit of the frame
- out_valid  output  1  dec/out_count/err_digit hold a completed frame
- out_ready  input  1  consumer takes the frame
- dec  output  4*NUM_DIGITS  packed frame; nibble 0 = least significant digit
- out_count  output  CNT_W  number of digits in the frame (1..NUM_DIGITS)
- err_digit  output  1  sticky: at least one digit >9 in the current frame

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = COLLECT.
  - dec = 0, digit counter = 0, out_count = 0, err_digit = 0, out_valid = 0.
- States: COLLECT, HOLD.
  - in_ready = (state == COLLECT).
  - out_valid = (state == HOLD).
  - Both are registered-state decodes, not combinational paths from inputs.
- Accept condition: in_valid && in_ready.
- Per accepted digit d:
  - Stored nibble d' = (d <= 9) ? d : 0.
  - If d > 9, err_digit is set and stays set until the frame is consumed or cleared.
  - MSD_FIRST=1: dec <= {dec[4*NUM_DIGITS-5:0], d'}.
  - MSD_FIRST=0: nibble[count] <= d'; all other nibbles unchanged.
  - count increments by 1.
- Frame completion, COLLECT -> HOLD:
  - Triggered on the accepting edge where in_last=1, or where count+1 == NUM_DIGITS; both together count once.
  - out_count latches count+1.
  - One-cycle latency: out_valid is high the cycle after the final digit is accepted.
- HOLD:
  - dec, out_count and err_digit are stable; in_valid is ignored (no accept).
  - On out_valid && out_ready: dec, count and err_digit are cleared to 0, and the state returns to COLLECT.
  - in_ready rises the following cycle, so there is no same-cycle consume-and-accept.
- Early termination: unused high nibbles remain 0. With MSD_FIRST=1 the frame is right-justified, so dec equals the received number.
- Output contents: out_count is valid only while out_valid; it reads 0 in COLLECT after consume. dec is visible (partial) during COLLECT.
- clear:
  - Has priority over accept and consume in any state.
  - Next edge: dec = 0, count = 0, err_digit = 0, state = COLLECT.
  - A digit presented in the same cycle as clear is dropped.
- Counter: never wraps. It is at most NUM_DIGITS-1 in COLLECT because reaching NUM_DIGITS forces HOLD.
- reset_n asserted mid-frame or mid-HOLD: immediate return to reset values; the frame is lost.
- in_last with in_valid low has no effect.

Test Plan:
- NUM_DIGITS=4, MSD_FIRST=1: send 1,2,3,4 (in_last=0), out_ready=0 -> out_valid one cycle after digit 4, dec=16'h1234, out_count=4, in_ready=0; hold 5 cycles and extra in_valid pulses leave dec unchanged; out_ready=1 -> dec=0, in_ready=1 next cycle.
- MSD_FIRST=1: send 7,5 with in_last on 5 -> dec=16'h0075, out_count=2, err_digit=0.
- MSD_FIRST=0: send 1,2,3 with in_last on 3 -> dec=16'h0321, out_count=3.
- Send 9,A,3,F -> dec=16'h9030, err_digit=1; after consume, send 2,in_last -> err_digit=0, dec=16'h0002.
- Send 4,6, then clear asserted with in_valid=1, digit 8 -> dec=0, count=0, digit 8 dropped; clear in HOLD -> out_valid falls, frame discarded.
- Default NUM_DIGITS=300: stream 300 digits (i mod 10) with random in_valid gaps and reset_n pulsed low mid-stream once -> outputs zero asynchronously; full rerun yields out_count=300, dec matching the reference-model concatenation, in_last never needed.
